// File: rtl/sd_sector_sched.sv
// sd_sector_sched: sequencer and arbiter in front of the single-block SD sector
// reader. Two requesters (0 = LCD picture loader, 1 = aux/config loader) each
// ask for a run of consecutive sectors. Every sector attempt is preceded by an
// idle gap, issued as a one-cycle rd_start, and retried on timeout or reader
// error up to MAX_RETRY times before the run is aborted with err.
//
// Optional build macro SCHED_PRIO_EN: fixed priority (requester 0 wins ties)
// instead of round-robin arbitration.
//
// GAP_CYCLES must be at least 1.

module sd_sector_sched #(
   parameter int unsigned GAP_CYCLES = 10000,
   parameter logic [21:0] TIMEOUT    = 22'd2000000,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned CNT_W      = 10
) (
   input  logic             SD_clk,
   input  logic             rst,
   // requester 0 (LCD picture loader)
   input  logic             req0_valid,
   input  logic [31:0]      req0_sec,
   input  logic [CNT_W-1:0] req0_cnt,
   output logic             req0_ready,
   output logic             req0_done,
   // requester 1 (auxiliary / config loader)
   input  logic             req1_valid,
   input  logic [31:0]      req1_sec,
   input  logic [CNT_W-1:0] req1_cnt,
   output logic             req1_ready,
   output logic             req1_done,
   // sector reader
   output logic             rd_start,
   output logic [31:0]      rd_sec,
   input  logic             rd_done,
   input  logic             rd_err,
   // status
   output logic             owner,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] sec_left
);

   // Gap counter holds 0 .. GAP_CYCLES-1.
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   // Retry counter holds 0 .. MAX_RETRY.
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StGap,
      StIssue,
      StWait,
      StNext,
      StFinish
   } state_e;

   state_e           state_q, state_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [21:0]      to_q, to_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic [31:0]      sec_q, sec_d;
   logic [CNT_W-1:0] left_q, left_d;
   logic             owner_q, owner_d;
   logic             err_q, err_d;

`ifndef SCHED_PRIO_EN
   // Requester that wins a tie; points away from whoever was served last.
   logic             prio_q, prio_d;
`endif

   logic             accept;
   logic             grant;
   logic             any_valid;
   logic [31:0]      grant_sec;
   logic [CNT_W-1:0] grant_cnt;
   logic             attempt_fail;

   assign any_valid = req0_valid | req1_valid;

   // Arbitration: pick the requester granted if an accept happens this cycle.
   always_comb begin
`ifdef SCHED_PRIO_EN
      grant = ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
         grant = prio_q;
      end else begin
         grant = req1_valid;
      end
`endif
      grant_sec = grant ? req1_sec : req0_sec;
      grant_cnt = grant ? req1_cnt : req0_cnt;
   end

   // A failed attempt: reader error or timeout, but rd_done always takes precedence.
   assign attempt_fail = ~rd_done & (rd_err | (to_q == (TIMEOUT - 22'd1)));

   // Next-state and pulse outputs of the run sequencer.
   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      to_d       = to_q;
      retry_d    = retry_q;
      sec_d      = sec_q;
      left_d     = left_q;
      owner_d    = owner_q;
      err_d      = err_q;
`ifndef SCHED_PRIO_EN
      prio_d     = prio_q;
`endif
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      req0_done  = 1'b0;
      req1_done  = 1'b0;
      rd_start   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               accept     = 1'b1;
               req0_ready = ~grant;
               req1_ready = grant;
               owner_d    = grant;
               sec_d      = grant_sec;
               left_d     = grant_cnt;
               err_d      = 1'b0;
               retry_d    = '0;
               gap_d      = '0;
               state_d    = (grant_cnt == '0) ? StFinish : StGap;
            end
         end

         StGap: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               gap_d   = '0;
               state_d = StIssue;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         StIssue: begin
            rd_start = 1'b1;
            to_d     = '0;
            state_d  = StWait;
         end

         StWait: begin
            if (rd_done) begin
               retry_d = '0;
               state_d = StNext;
            end else if (attempt_fail) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + RW'(1);
                  gap_d   = '0;
                  state_d = StGap;
               end else begin
                  err_d   = 1'b1;
                  state_d = StFinish;
               end
            end else begin
               to_d = to_q + 22'd1;
            end
         end

         StNext: begin
            // Address wraps modulo 2^32 without complaint.
            sec_d  = sec_q + 32'd1;
            left_d = left_q - CNT_W'(1);
            if (left_q == CNT_W'(1)) begin
               state_d = StFinish;
            end else if (GAP_CYCLES <= 1) begin
               state_d = StIssue;
            end else begin
               // This cycle already counts as the first idle gap cycle.
               gap_d   = GW'(1);
               state_d = StGap;
            end
         end

         StFinish: begin
            req0_done = ~owner_q;
            req1_done = owner_q;
`ifndef SCHED_PRIO_EN
            prio_d    = ~owner_q;
`endif
            state_d   = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge SD_clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         gap_q   <= '0;
         to_q    <= '0;
         retry_q <= '0;
         sec_q   <= '0;
         left_q  <= '0;
         owner_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         to_q    <= to_d;
         retry_q <= retry_d;
         sec_q   <= sec_d;
         left_q  <= left_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

`ifndef SCHED_PRIO_EN
   // Round-robin pointer; requester 0 wins the first tie after reset.
   always_ff @(posedge SD_clk or posedge rst) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end
`endif

   // Status outputs; the accept cycle already reports the new owner and clears err.
   always_comb begin
      busy     = accept | (state_q inside {StGap, StIssue, StWait, StNext});
      owner    = accept ? grant : owner_q;
      err      = err_q & ~accept;
      rd_sec   = sec_q;
      sec_left = left_q;
   end

`ifndef SYNTHESIS
   a_ready_onehot : assert property (@(posedge SD_clk) disable iff (rst)
      !(req0_ready && req1_ready));
   a_done_onehot : assert property (@(posedge SD_clk) disable iff (rst)
      !(req0_done && req1_done));
   a_sec_stable : assert property (@(posedge SD_clk) disable iff (rst)
      (state_q == StWait) |-> $stable(rd_sec));
   a_retry_bound : assert property (@(posedge SD_clk) disable iff (rst)
      retry_q <= RW'(MAX_RETRY));
`endif

endmodule

// File: tb/tb_sd_sector_sched.sv
// Scoreboard bench for sd_sector_sched (GAP_CYCLES=4, TIMEOUT=50). Stimulus
// pushes expected DUT pulses (kind, value, cycles since previous pulse) into a
// queue; a negedge monitor pops and compares every pulse the DUT produces.
// A reader model answers each rd_start 20 cycles later according to a plan queue.

module tb_sd_sector_sched;

   localparam int unsigned CNT_W = 10;

   // event kinds
   localparam int K_RDY0 = 0;
   localparam int K_RDY1 = 1;
   localparam int K_START = 2;
   localparam int K_DONE0 = 3;
   localparam int K_DONE1 = 4;

   // reader responses
   localparam int P_DONE = 0;
   localparam int P_ERR = 1;
   localparam int P_NONE = 2;

   logic             SD_clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid;
   logic [31:0]      req0_sec, req1_sec;
   logic [CNT_W-1:0] req0_cnt, req1_cnt;
   logic             req0_ready, req1_ready, req0_done, req1_done;
   logic             rd_start, rd_done, rd_err;
   logic [31:0]      rd_sec;
   logic             owner, busy, err;
   logic [CNT_W-1:0] sec_left;

   typedef struct {
      int          kind;
      logic [63:0] val;
      int          delta;
   } ev_t;

   ev_t exp_q[$];
   int  plan_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  last_cyc = 0;

   sd_sector_sched #(
      .GAP_CYCLES(4),
      .TIMEOUT   (22'd50),
      .MAX_RETRY (3),
      .CNT_W     (CNT_W)
   ) dut (
      .SD_clk    (SD_clk),
      .rst       (rst),
      .req0_valid(req0_valid),
      .req0_sec  (req0_sec),
      .req0_cnt  (req0_cnt),
      .req0_ready(req0_ready),
      .req0_done (req0_done),
      .req1_valid(req1_valid),
      .req1_sec  (req1_sec),
      .req1_cnt  (req1_cnt),
      .req1_ready(req1_ready),
      .req1_done (req1_done),
      .rd_start  (rd_start),
      .rd_sec    (rd_sec),
      .rd_done   (rd_done),
      .rd_err    (rd_err),
      .owner     (owner),
      .busy      (busy),
      .err       (err),
      .sec_left  (sec_left)
   );

   always #5 SD_clk = ~SD_clk;

   always @(posedge SD_clk) cyc <= cyc + 1;

   task automatic expect_ev(input int kind, input logic [63:0] val, input int delta);
      ev_t e;
      e.kind  = kind;
      e.val   = val;
      e.delta = delta;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input int kind, input logic [63:0] val);
      ev_t e;
      int  d;
      d        = cyc - last_cyc;
      last_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_pulse: got kind %0d val %h at cycle %0d, required no pulse",
                  kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || (e.delta >= 0 && e.delta != d)) begin
            errors++;
            $display("FAIL pulse_%0d: got kind %0d val %h delta %0d, required kind %0d val %h delta %0d",
                     checks, kind, val, d, e.kind, e.val, e.delta);
         end
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Monitor: every DUT pulse is matched against the scoreboard.
   always @(negedge SD_clk) begin
      if (!rst) begin
         if (req0_ready) check_ev(K_RDY0, 64'd0);
         if (req1_ready) check_ev(K_RDY1, 64'd0);
         if (rd_start)   check_ev(K_START, {32'd0, rd_sec});
         if (req0_done)  check_ev(K_DONE0, {53'd0, sec_left, err});
         if (req1_done)  check_ev(K_DONE1, {53'd0, sec_left, err});
      end
   end

   // Reader model: answer in the 20th cycle after rd_start per plan (default rd_done).
   always begin : reader
      int p;
      @(negedge SD_clk);
      if (rd_start && !rst) begin
         p = (plan_q.size() > 0) ? plan_q.pop_front() : P_DONE;
         if (p != P_NONE) begin
            repeat (20) @(negedge SD_clk);
            if (p == P_DONE) rd_done = 1'b1;
            else rd_err = 1'b1;
            @(negedge SD_clk);
            rd_done = 1'b0;
            rd_err  = 1'b0;
         end
      end
   end

   initial begin
      repeat (50000) @(posedge SD_clk);
      $display("FAIL watchdog: got no end of run after 50000 cycles, required completion");
      $fatal(1);
   end

   task automatic wait_ready(input bit n);
      int k;
      k = 0;
      do begin
         @(negedge SD_clk);
         k++;
      end while (!(n ? req1_ready : req0_ready) && k < 2000);
      if (k >= 2000) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got no req%0d_ready in 2000 cycles, required accept", n);
      end
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      do begin
         @(negedge SD_clk);
         k++;
      end while (!(req0_done || req1_done) && k < 2000);
      if (k >= 2000) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done pulse in 2000 cycles, required done");
      end
      @(posedge SD_clk);
      #1;
   endtask

   task automatic do_req(input bit n, input logic [31:0] sec, input logic [CNT_W-1:0] cnt);
      @(posedge SD_clk);
      #1;
      if (n) begin
         req1_sec = sec; req1_cnt = cnt; req1_valid = 1'b1;
      end else begin
         req0_sec = sec; req0_cnt = cnt; req0_valid = 1'b1;
      end
      wait_ready(n);
      @(posedge SD_clk);
      #1;
      if (n) req1_valid = 1'b0;
      else req0_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_sec = '0; req0_cnt = '0;
      req1_valid = 1'b0; req1_sec = '0; req1_cnt = '0;
      rd_done = 1'b0; rd_err = 1'b0;
      repeat (3) @(negedge SD_clk);
      check_val("reset_outputs",
                {req0_ready, req1_ready, req0_done, req1_done, rd_start, owner, busy, err},
                64'd0);
      check_val("reset_rd_sec", rd_sec, 64'd0);
      check_val("reset_sec_left", sec_left, 64'd0);
      @(posedge SD_clk);
      #1 rst = 1'b0;

      // Single run of three sectors.
      expect_ev(K_RDY0, 64'd0, -1);
      expect_ev(K_START, 64'd16448, 5);
      expect_ev(K_START, 64'd16449, 25);
      expect_ev(K_START, 64'd16450, 25);
      expect_ev(K_DONE0, {53'd0, 10'd0, 1'b0}, 22);
      do_req(1'b0, 32'd16448, 10'd3);
      @(negedge SD_clk);
      check_val("run_busy_owner_left", {busy, owner, sec_left}, {52'd0, 1'b1, 1'b0, 10'd3});
      wait_done();
      check_val("after_run_busy", busy, 64'd0);

      // Zero-count run: done right after accept, no reader traffic.
      expect_ev(K_RDY1, 64'd0, -1);
      expect_ev(K_DONE1, {53'd0, 10'd0, 1'b0}, 1);
      do_req(1'b1, 32'd5, 10'd0);
      wait_done();

      // Tie, with requester 0 re-asserting right after its first accept.
      expect_ev(K_RDY0, 64'd0, -1);
      expect_ev(K_START, 64'd200, 5);
      expect_ev(K_DONE0, {53'd0, 10'd0, 1'b0}, 22);
`ifdef SCHED_PRIO_EN
      expect_ev(K_RDY0, 64'd0, 1);
      expect_ev(K_START, 64'd210, 5);
      expect_ev(K_DONE0, {53'd0, 10'd0, 1'b0}, 22);
      expect_ev(K_RDY1, 64'd0, 1);
      expect_ev(K_START, 64'd300, 5);
      expect_ev(K_DONE1, {53'd0, 10'd0, 1'b0}, 22);
`else
      expect_ev(K_RDY1, 64'd0, 1);
      expect_ev(K_START, 64'd300, 5);
      expect_ev(K_DONE1, {53'd0, 10'd0, 1'b0}, 22);
      expect_ev(K_RDY0, 64'd0, 1);
      expect_ev(K_START, 64'd210, 5);
      expect_ev(K_DONE0, {53'd0, 10'd0, 1'b0}, 22);
`endif
      @(posedge SD_clk);
      #1;
      req0_sec = 32'd200; req0_cnt = 10'd1; req0_valid = 1'b1;
      req1_sec = 32'd300; req1_cnt = 10'd1; req1_valid = 1'b1;
      fork
         begin
            wait_ready(1'b0);
            @(posedge SD_clk);
            #1 req0_sec = 32'd210;
            wait_ready(1'b0);
            @(posedge SD_clk);
            #1 req0_valid = 1'b0;
         end
         begin
            wait_ready(1'b1);
            @(posedge SD_clk);
            #1 req1_valid = 1'b0;
         end
      join
      wait_done();

      // Two reader errors on sector 100, then success.
      plan_q.push_back(P_ERR);
      plan_q.push_back(P_ERR);
      plan_q.push_back(P_DONE);
      expect_ev(K_RDY1, 64'd0, -1);
      expect_ev(K_START, 64'd100, 5);
      expect_ev(K_START, 64'd100, 25);
      expect_ev(K_START, 64'd100, 25);
      expect_ev(K_DONE1, {53'd0, 10'd0, 1'b0}, 22);
      do_req(1'b1, 32'd100, 10'd1);
      wait_done();

      // Reader silent: four timed-out attempts, then abort with sec_left untouched.
      repeat (4) plan_q.push_back(P_NONE);
      expect_ev(K_RDY0, 64'd0, -1);
      expect_ev(K_START, 64'd7, 5);
      expect_ev(K_START, 64'd7, 55);
      expect_ev(K_START, 64'd7, 55);
      expect_ev(K_START, 64'd7, 55);
      expect_ev(K_DONE0, {53'd0, 10'd2, 1'b1}, 51);
      do_req(1'b0, 32'd7, 10'd2);
      wait_done();
      repeat (3) @(negedge SD_clk);
      check_val("err_held", {busy, err}, 64'd1);

      // Address wrap; the accept also clears the held err.
      expect_ev(K_RDY0, 64'd0, -1);
      expect_ev(K_START, 64'hFFFF_FFFF, 5);
      expect_ev(K_START, 64'd0, 25);
      expect_ev(K_DONE0, {53'd0, 10'd0, 1'b0}, 22);
      do_req(1'b0, 32'hFFFF_FFFF, 10'd2);
      wait_done();
      check_val("err_cleared", err, 64'd0);

      // Reset in the middle of WAIT: no done pulse, then a clean restart.
      plan_q.push_back(P_NONE);
      expect_ev(K_RDY1, 64'd0, -1);
      expect_ev(K_START, 64'd1000, 5);
      do_req(1'b1, 32'd1000, 10'd3);
      repeat (10) @(negedge SD_clk);
      @(posedge SD_clk);
      #1 rst = 1'b1;
      @(negedge SD_clk);
      check_val("midrun_reset_state", {busy, err, rd_start, sec_left}, 64'd0);
      check_val("midrun_reset_rd_sec", rd_sec, 64'd0);
      @(posedge SD_clk);
      #1 rst = 1'b0;
      repeat (40) @(negedge SD_clk);
      check_val("no_done_after_reset", exp_q.size(), 64'd0);
      expect_ev(K_RDY1, 64'd0, -1);
      expect_ev(K_START, 64'd1000, 5);
      expect_ev(K_DONE1, {53'd0, 10'd0, 1'b0}, 22);
      do_req(1'b1, 32'd1000, 10'd1);
      wait_done();

      repeat (5) @(negedge SD_clk);
      check_val("scoreboard_empty", exp_q.size(), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
